serial_adder: RTL and testbench

Bit-serial N-bit adder built around a one-bit full-adder cell. Each cycle it presents one operand bit pair plus the registered carry to the cell, then shifts the sum bit into a result register. It sits directly upstream of the one-bit adder and feeds it, turning the combinational 1-bit stage into a multi-cycle N-bit operator with a start/done handshake. Trades N+1 cycles of latency for a single adder cell.

---
 rtl/adder_pkg.sv | 20 ++
 rtl/serial_adder_if.sv | 30 +++
 rtl/add1b_full.sv | 20 ++
 rtl/serial_adder.sv | 117 +++++++++++
 tb/tb_serial_adder.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
//   state_t   : controller states (IDLE, RUN, DONE)
//   cnt_width : width of the bit counter for an N-bit operand
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // clog2(n+1) lets the counter hold every value 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder.
//   start    : request, sampled only when the adder is not busy
//   a, b     : operands, captured in the cycle start is accepted
//   busy     : an addition is in progress
//   done     : one-cycle pulse, sum/cout have just been updated
//   sum,cout : registered result and carry out of bit N-1
// master drives the request; slave is the adder itself.
interface serial_adder_if #(
  parameter int unsigned N = 8
);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/add1b_full.sv
// One-bit full adder cell, purely combinational.
//   x, y     : operand bits
//   cin      : carry in
//   result   : sum bit
//   retenue  : carry out
module add1b_full (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic result,
  output logic retenue
);

  logic p;

  assign p       = x ^ y;
  assign result  = p ^ cin;
  assign retenue = (x & y) | (cin & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one operand bit pair per cycle through a single
// full-adder cell, LSB first, with a start/busy/done handshake.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : serial_adder_if slave (start, a, b in; busy, done, sum, cout out)
// N must match the N of the connected interface (legal range 1..32).
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int unsigned CW = cnt_width(N);

  state_t         state, state_nxt;
  logic [N-1:0]   sa, sa_nxt;
  logic [N-1:0]   sb, sb_nxt;
  logic [N-1:0]   acc, acc_nxt;
  logic           c, c_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [N-1:0]   sum_q, sum_nxt;
  logic           cout_q, cout_nxt;
  logic           busy_q;
  logic           done_q;

  logic           fa_sum;
  logic           fa_carry;

  // Single adder cell, always looking at the current LSBs and stored carry.
  add1b_full u_fa (
    .x       (sa[0]),
    .y       (sb[0]),
    .cin     (c),
    .result  (fa_sum),
    .retenue (fa_carry)
  );

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    sa_nxt    = sa;
    sb_nxt    = sb;
    acc_nxt   = acc;
    c_nxt     = c;
    cnt_nxt   = cnt;
    sum_nxt   = sum_q;
    cout_nxt  = cout_q;

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = RUN;
          sa_nxt    = bus.a;
          sb_nxt    = bus.b;
          c_nxt     = 1'b0;
          cnt_nxt   = '0;
        end else begin
          state_nxt = IDLE;
        end
      end

      RUN: begin
        sa_nxt  = sa >> 1;
        sb_nxt  = sb >> 1;
        c_nxt   = fa_carry;
        // New sum bit enters at the MSB; after N shifts bit 0 sits at acc[0].
        acc_nxt = (acc >> 1) | (N'(fa_sum) << (N - 1));
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          state_nxt = DONE;
          sum_nxt   = acc_nxt;
          cout_nxt  = fa_carry;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; busy/done are decoded from the next state
  // so they are flops that track state==RUN / state==DONE exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      acc    <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      sa     <= sa_nxt;
      sb     <= sb_nxt;
      acc    <= acc_nxt;
      c      <= c_nxt;
      cnt    <= cnt_nxt;
      sum_q  <= sum_nxt;
      cout_q <= cout_nxt;
      busy_q <= (state_nxt == RUN);
      done_q <= (state_nxt == DONE);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios plus a random
// sweep, checked against plain integer addition.
module tb_serial_adder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   overlap;

  serial_adder_if #(.N(8)) bus8 ();
  serial_adder_if #(.N(1)) bus1 ();

  serial_adder #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.N(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // busy and done must never be high together
  always @(negedge clk) begin
    if ((bus8.busy && bus8.done) || (bus1.busy && bus1.done)) overlap++;
  end

  // Issue one N=8 operation; lat = edges from start sample to done (-1 on timeout).
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] s, output logic co,
                         output int lat, output int busy_cyc);
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat = 0; busy_cyc = 0;
    while (!bus8.done && lat < 40) begin
      if (bus8.busy) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (!bus8.done) lat = -1;
    s  = bus8.sum;
    co = bus8.cout;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus8.busy); end
    checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus8.done); end
    checks++; if (bus8.sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h expected 00", bus8.sum); end
    checks++; if (bus8.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", bus8.cout); end
    checks++; if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin errors++; $display("FAIL reset_n1_flags: got %b%b expected 00", bus1.busy, bus1.done); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] s; logic co; int lat, bc;
    run_op8(8'h5A, 8'h33, s, co, lat, bc);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    checks++; if (s !== 8'h8D) begin errors++; $display("FAIL basic_sum: got %h expected 8d", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b expected 0", co); end
    checks++; if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
  endtask

  task automatic test_carry;
    logic [7:0] av [3] = '{8'hFF, 8'h80, 8'h00};
    logic [7:0] bv [3] = '{8'h01, 8'h80, 8'h00};
    logic [8:0] e; logic [7:0] s; logic co; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      e = {1'b0, av[i]} + {1'b0, bv[i]};
      run_op8(av[i], bv[i], s, co, lat, bc);
      checks++; if ({co, s} !== e) begin errors++; $display("FAIL carry_case%0d: got %b_%h expected %b_%h", i, co, s, e[8], e[7:0]); end
    end
  endtask

  task automatic test_start_held;
    int lat, pulses;
    @(negedge clk);
    bus8.a = 8'h01; bus8.b = 8'h01; bus8.start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!bus8.done && lat < 40) begin
      if (lat == 3) bus8.a = 8'hF0;
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 8) begin errors++; $display("FAIL held_latency: got %0d expected 8", lat); end
    checks++; if (bus8.sum !== 8'h02) begin errors++; $display("FAIL held_sum: got %h expected 02", bus8.sum); end
    pulses = bus8.done ? 1 : 0;
    @(negedge clk);
    bus8.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus8.done) pulses++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL held_done_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    bus8.a = 8'h5A; bus8.b = 8'h33; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat = 0;
    while (!bus8.done && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (bus8.done !== 1'b1 || bus8.sum !== 8'h8D) begin errors++; $display("FAIL b2b_first: got done=%b sum=%h expected done=1 sum=8d", bus8.done, bus8.sum); end
    // request lands in the DONE cycle
    bus8.a = 8'h10; bus8.b = 8'h20; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    checks++; if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin errors++; $display("FAIL b2b_restart: got busy=%b done=%b expected busy=1 done=0", bus8.busy, bus8.done); end
    checks++; if (bus8.sum !== 8'h8D) begin errors++; $display("FAIL b2b_sum_hold: got %h expected 8d", bus8.sum); end
    lat = 0;
    while (!bus8.done && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_latency: got %0d expected 8", lat); end
    checks++; if (bus8.sum !== 8'h30 || bus8.cout !== 1'b0) begin errors++; $display("FAIL b2b_second: got %b_%h expected 0_30", bus8.cout, bus8.sum); end
  endtask

  task automatic test_reset_midrun;
    logic [7:0] s; logic co; int lat, bc, pulses;
    @(negedge clk);
    bus8.a = 8'hC3; bus8.b = 8'h7E; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({bus8.busy, bus8.done, bus8.cout} !== 3'b000) begin errors++; $display("FAIL midrst_flags: got busy,done,cout=%b expected 000", {bus8.busy, bus8.done, bus8.cout}); end
    checks++; if (bus8.sum !== 8'h00) begin errors++; $display("FAIL midrst_sum: got %h expected 00", bus8.sum); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus8.done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", pulses); end
    run_op8(8'h12, 8'h34, s, co, lat, bc);
    checks++; if ({co, s} !== 9'h046 || lat !== 8) begin errors++; $display("FAIL midrst_fresh: got %b_%h lat %0d expected 0_46 lat 8", co, s, lat); end
  endtask

  task automatic test_n1;
    int lat;
    @(negedge clk);
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    checks++; if (bus1.busy !== 1'b1) begin errors++; $display("FAIL n1_busy: got %b expected 1", bus1.busy); end
    lat = 0;
    while (!bus1.done && lat < 10) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 1) begin errors++; $display("FAIL n1_latency: got %0d expected 1", lat); end
    checks++; if (bus1.sum !== 1'b0 || bus1.cout !== 1'b1) begin errors++; $display("FAIL n1_result: got %b_%b expected 1_0", bus1.cout, bus1.sum); end
  endtask

  task automatic test_random;
    logic [7:0] a, b, s; logic co; logic [8:0] e; int lat, bc;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      e = 9'(int'(a) + int'(b));
      run_op8(a, b, s, co, lat, bc);
      checks++;
      if ({co, s} !== e || lat !== 8) begin
        errors++;
        $display("FAIL random_%0d: %h+%h got %b_%h lat %0d expected %b_%h lat 8", i, a, b, co, s, lat, e[8], e[7:0]);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; overlap = 0;
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
    test_reset();
    test_basic();
    test_carry();
    test_start_held();
    test_back_to_back();
    test_reset_midrun();
    test_n1();
    test_random();
    checks++; if (overlap !== 0) begin errors++; $display("FAIL busy_done_overlap: got %0d cycles expected 0", overlap); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
